// File: rtl/debug_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : debug_mem_master
// Description : Host-side driver for the core's debug memory ports
//               (InstRAM/DataRAM port 2). Accepts word commands over a
//               valid/ready channel (single write, burst read, burst fill,
//               run/hold). Drives port 2 of the selected RAM and returns read
//               words over a valid/ready response channel. Owns cpu_hold,
//               which the top level ORs into the core reset so the core stays
//               in reset while a program is loaded.
// Parameters  : LEN_W  - width of cmd_len; a burst moves cmd_len+1 words
//               RD_LAT - RAM port-2 read latency in cycles (1..3)
// Ports       : clk, rst                      clock, async active-high reset
//               cmd_valid/cmd_ready           command handshake
//               cmd_op/sel/addr/wdata/be/len  command fields
//               rsp_valid/rsp_ready           response handshake
//               rsp_data/rsp_last             read word, final-word flag
//               busy, cpu_hold                status, core hold
//               inst_a2/wd2/we2/rd2           InstRAM port 2
//               data_a2/wd2/we2/rd2           DataRAM port 2
// Revision    : 1.0 - initial release
// ============================================================================
module debug_mem_master #(
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_sel,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_be,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_last,
    output logic             busy,
    output logic             cpu_hold,
    output logic [31:0]      inst_a2,
    output logic [31:0]      inst_wd2,
    output logic [3:0]       inst_we2,
    input  logic [31:0]      inst_rd2,
    output logic [31:0]      data_a2,
    output logic [31:0]      data_wd2,
    output logic [3:0]       data_we2,
    input  logic [31:0]      data_rd2
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WR       = 3'd1;
    localparam logic [2:0] c_FILL     = 3'd2;
    localparam logic [2:0] c_RD_ISSUE = 3'd3;
    localparam logic [2:0] c_RD_WAIT  = 3'd4;
    localparam logic [2:0] c_RD_RSP   = 3'd5;

    localparam logic [1:0] c_OP_WRITE = 2'b00;
    localparam logic [1:0] c_OP_READ  = 2'b01;
    localparam logic [1:0] c_OP_FILL  = 2'b10;
    localparam logic [1:0] c_OP_RUN   = 2'b11;

    // RD_WAIT lasts RD_LAT-1 cycles; the counter is loaded with one less
    // because the cycle in which it reaches zero is itself a wait cycle.
    localparam logic [1:0]  c_WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_WORD_STEP = 32'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_nextState;
    logic             r_outOfReset;
    logic             r_sel;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [LEN_W-1:0] r_cnt;
    logic [1:0]       r_wait;
    logic [31:0]      r_rspData;
    logic             r_rspValid;
    logic             r_rspLast;
    logic             r_cpuHold;

    logic             w_accept;
    logic             w_lastWord;
    logic             w_capture;
    logic             w_drive;
    logic             w_write;

    // r_outOfReset keeps cmd_ready low while rst is asserted and until the
    // first clock edge after it is released.
    assign cmd_ready  = r_outOfReset && (r_state == c_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    // r_cnt counts remaining words down to zero, so the full 2^LEN_W-word
    // burst (cmd_len all ones) never needs a wider counter.
    assign w_lastWord = (r_cnt == '0);

    assign busy      = (r_state != c_IDLE);
    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    assign rsp_last  = r_rspLast;
    assign cpu_hold  = r_cpuHold;

    // Edge on which RD2 is valid for the address being held.
    generate
        if (RD_LAT == 1) begin : g_latOne
            assign w_capture = (r_state == c_RD_ISSUE);
        end else begin : g_latMulti
            assign w_capture = (r_state == c_RD_WAIT) && (r_wait == 2'd0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_drive     = 1'b0;
        w_write     = 1'b0;
        inst_a2     = '0;
        inst_wd2    = '0;
        inst_we2    = '0;
        data_a2     = '0;
        data_wd2    = '0;
        data_we2    = '0;

        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_WRITE: w_nextState = c_WR;
                        c_OP_READ:  w_nextState = c_RD_ISSUE;
                        c_OP_FILL:  w_nextState = c_FILL;
                        default:    w_nextState = c_IDLE;
                    endcase
                end
            end
            c_WR: begin
                w_drive     = 1'b1;
                w_write     = 1'b1;
                w_nextState = c_IDLE;
            end
            c_FILL: begin
                w_drive = 1'b1;
                w_write = 1'b1;
                if (w_lastWord) begin
                    w_nextState = c_IDLE;
                end
            end
            c_RD_ISSUE: begin
                w_drive     = 1'b1;
                w_nextState = (RD_LAT == 1) ? c_RD_RSP : c_RD_WAIT;
            end
            c_RD_WAIT: begin
                w_drive = 1'b1;
                if (r_wait == 2'd0) begin
                    w_nextState = c_RD_RSP;
                end
            end
            c_RD_RSP: begin
                if (rsp_ready) begin
                    w_nextState = w_lastWord ? c_IDLE : c_RD_ISSUE;
                end
            end
            default: w_nextState = c_IDLE;
        endcase

        // Only the selected RAM sees traffic; the other port stays at zero.
        if (w_drive) begin
            if (r_sel) begin
                data_a2  = r_addr;
                data_wd2 = w_write ? r_wdata : 32'd0;
                data_we2 = w_write ? r_be : 4'd0;
            end else begin
                inst_a2  = r_addr;
                inst_wd2 = w_write ? r_wdata : 32'd0;
                inst_we2 = w_write ? r_be : 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command capture, address/count stepping, response register, hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outOfReset <= 1'b0;
            r_sel        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_cnt        <= '0;
            r_wait       <= '0;
            r_rspData    <= '0;
            r_rspValid   <= 1'b0;
            r_rspLast    <= 1'b0;
            r_cpuHold    <= 1'b1;
        end else begin
            r_outOfReset <= 1'b1;

            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_sel   <= cmd_sel;
                        r_addr  <= cmd_addr & c_WORD_MASK;
                        r_wdata <= cmd_wdata;
                        r_be    <= cmd_be;
                        r_cnt   <= cmd_len;
                        if (cmd_op == c_OP_RUN) begin
                            r_cpuHold <= cmd_wdata[0];
                        end
                    end
                end
                c_FILL: begin
                    if (!w_lastWord) begin
                        r_cnt  <= r_cnt - LEN_W'(1);
                        r_addr <= r_addr + c_WORD_STEP;
                    end
                end
                c_RD_ISSUE: begin
                    r_wait <= c_WAIT_INIT;
                end
                c_RD_WAIT: begin
                    if (r_wait != 2'd0) begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                c_RD_RSP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_rspLast  <= 1'b0;
                        if (!w_lastWord) begin
                            r_cnt  <= r_cnt - LEN_W'(1);
                            r_addr <= r_addr + c_WORD_STEP;
                        end
                    end
                end
                default: ;
            endcase

            if (w_capture) begin
                r_rspData  <= r_sel ? data_rd2 : inst_rd2;
                r_rspValid <= 1'b1;
                r_rspLast  <= w_lastWord;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_mem_master
// Description : Self-checking bench for debug_mem_master. Two instances are
//               built (RD_LAT=1 and RD_LAT=3) with LEN_W=4 so that the
//               full-length burst is short. Each instance is attached to a
//               pair of behavioural RAMs; a word-level shadow memory predicts
//               every read and every port-2 write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_mem_master;

    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          cmd_valid [2];
    logic          cmd_ready [2];
    logic [1:0]    cmd_op    [2];
    logic          cmd_sel   [2];
    logic [31:0]   cmd_addr  [2];
    logic [31:0]   cmd_wdata [2];
    logic [3:0]    cmd_be    [2];
    logic [LW-1:0] cmd_len   [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [31:0]   rsp_data  [2];
    logic          rsp_last  [2];
    logic          busy      [2];
    logic          cpu_hold  [2];
    logic [31:0]   inst_a2   [2];
    logic [31:0]   inst_wd2  [2];
    logic [3:0]    inst_we2  [2];
    logic [31:0]   inst_rd2  [2];
    logic [31:0]   data_a2   [2];
    logic [31:0]   data_wd2  [2];
    logic [3:0]    data_we2  [2];
    logic [31:0]   data_rd2  [2];

    always #5 clk = ~clk;

    debug_mem_master #(.LEN_W(LW), .RD_LAT(1)) dutA (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_sel(cmd_sel[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .cmd_be(cmd_be[0]), .cmd_len(cmd_len[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_last(rsp_last[0]), .busy(busy[0]), .cpu_hold(cpu_hold[0]),
        .inst_a2(inst_a2[0]), .inst_wd2(inst_wd2[0]), .inst_we2(inst_we2[0]),
        .inst_rd2(inst_rd2[0]),
        .data_a2(data_a2[0]), .data_wd2(data_wd2[0]), .data_we2(data_we2[0]),
        .data_rd2(data_rd2[0])
    );

    debug_mem_master #(.LEN_W(LW), .RD_LAT(3)) dutB (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_sel(cmd_sel[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .cmd_be(cmd_be[1]), .cmd_len(cmd_len[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_last(rsp_last[1]), .busy(busy[1]), .cpu_hold(cpu_hold[1]),
        .inst_a2(inst_a2[1]), .inst_wd2(inst_wd2[1]), .inst_we2(inst_we2[1]),
        .inst_rd2(inst_rd2[1]),
        .data_a2(data_a2[1]), .data_wd2(data_wd2[1]), .data_we2(data_we2[1]),
        .data_rd2(data_rd2[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit [31:0] keyOf(input int k, input bit sel, input bit [31:0] a);
        return {k[0], sel, a[31:2]};
    endfunction

    function automatic bit [31:0] mergeBe(input bit [31:0] old, input bit [31:0] d, input bit [3:0] be);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural RAMs: byte-enabled writes on the clock edge, reads that
    // present the word RD_LAT cycles after the address is first driven.
    // ------------------------------------------------------------------
    bit [31:0] ram    [bit [31:0]];
    bit [31:0] shadow [bit [31:0]];
    bit [69:0] actLog [$];
    bit [69:0] expLog [$];
    logic [31:0] instD1 [2], instD2 [2], dataD1 [2], dataD2 [2];

    function automatic bit [31:0] ramRead(input int k, input bit sel, input bit [31:0] a);
        bit [31:0] key;
        key = keyOf(k, sel, a);
        return ram.exists(key) ? ram[key] : 32'd0;
    endfunction

    function automatic bit [31:0] shadowRead(input int k, input bit sel, input bit [31:0] a);
        bit [31:0] key;
        key = keyOf(k, sel, a);
        return shadow.exists(key) ? shadow[key] : 32'd0;
    endfunction

    task automatic ramWrite(input int k, input bit sel, input bit [31:0] a, input bit [31:0] d, input bit [3:0] be);
        bit [31:0] key;
        key = keyOf(k, sel, a);
        ram[key] = mergeBe(ramRead(k, sel, a), d, be);
        actLog.push_back({k[0], sel, a, d, be});
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (inst_we2[k] != 4'd0) ramWrite(k, 1'b0, inst_a2[k], inst_wd2[k], inst_we2[k]);
            if (data_we2[k] != 4'd0) ramWrite(k, 1'b1, data_a2[k], data_wd2[k], data_we2[k]);
            instD1[k] <= inst_a2[k];
            instD2[k] <= instD1[k];
            dataD1[k] <= data_a2[k];
            dataD2[k] <= dataD1[k];
        end
    end

    always @(negedge clk) begin
        inst_rd2[0] = ramRead(0, 1'b0, inst_a2[0]);
        data_rd2[0] = ramRead(0, 1'b1, data_a2[0]);
        inst_rd2[1] = ramRead(1, 1'b0, instD2[1]);
        data_rd2[1] = ramRead(1, 1'b1, dataD2[1]);
    end

    // ------------------------------------------------------------------
    // Port-quietness monitor
    // ------------------------------------------------------------------
    bit   monEn = 1'b0;
    logic curSel [2];

    always @(negedge clk) begin
        if (monEn) begin
            for (int k = 0; k < 2; k++) begin
                check("ready_vs_busy", cmd_ready[k], !busy[k]);
                if (!busy[k])
                    check("idle_ports_zero", |{inst_a2[k], inst_wd2[k], inst_we2[k],
                                               data_a2[k], data_wd2[k], data_we2[k]}, 1'b0);
                else if (curSel[k])
                    check("unsel_inst_zero", |{inst_a2[k], inst_wd2[k], inst_we2[k]}, 1'b0);
                else
                    check("unsel_data_zero", |{data_a2[k], data_wd2[k], data_we2[k]}, 1'b0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Command helpers
    // ------------------------------------------------------------------
    task automatic issue(input int k, input bit [1:0] op, input bit sel, input bit [31:0] addr,
                         input bit [31:0] wdata, input bit [3:0] be, input int len);
        int n;
        n = 0;
        @(negedge clk);
        cmd_op[k]    = op;
        cmd_sel[k]   = sel;
        cmd_addr[k]  = addr;
        cmd_wdata[k] = wdata;
        cmd_be[k]    = be;
        cmd_len[k]   = LW'(len);
        cmd_valid[k] = 1'b1;
        while (cmd_ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready[k], 1'b1);
        @(posedge clk);
        #1;
        cmd_valid[k] = 1'b0;
        curSel[k]    = sel;
    endtask

    task automatic expectWrites(input int k, input bit sel, input bit [31:0] addr,
                                input bit [31:0] d, input bit [3:0] be, input int len);
        bit [31:0] a;
        for (int i = 0; i <= len; i++) begin
            a = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
            if (be != 4'd0) begin
                expLog.push_back({k[0], sel, a, d, be});
                shadow[keyOf(k, sel, a)] = mergeBe(shadowRead(k, sel, a), d, be);
            end
        end
    endtask

    task automatic waitIdle(input int k, input string tag, input int expCycles);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!busy[k]) break;
            n++;
        end
        check(tag, n, expCycles);
    endtask

    task automatic compareLog(input string tag);
        check({tag, "_count"}, actLog.size(), expLog.size());
        for (int i = 0; i < actLog.size() && i < expLog.size(); i++)
            check(tag, actLog[i], expLog[i]);
        actLog.delete();
        expLog.delete();
    endtask

    task automatic doWrite(input int k, input bit sel, input bit [31:0] addr, input bit [31:0] d, input bit [3:0] be);
        issue(k, 2'b00, sel, addr, d, be, $urandom_range(0, 15));
        expectWrites(k, sel, addr, d, be, 0);
        waitIdle(k, "wr_busy_cycles", 1);
        compareLog("wr_log");
    endtask

    task automatic doFill(input int k, input bit sel, input bit [31:0] addr, input bit [31:0] d,
                          input bit [3:0] be, input int len);
        issue(k, 2'b10, sel, addr, d, be, len);
        expectWrites(k, sel, addr, d, be, len);
        waitIdle(k, "fill_busy_cycles", len + 1);
        compareLog("fill_log");
    endtask

    task automatic doRun(input int k, input bit v);
        issue(k, 2'b11, $urandom_range(0, 1), $urandom, {31'($urandom), v}, 4'($urandom), 0);
        check("run_hold", cpu_hold[k], v);
        check("run_busy", busy[k], 1'b0);
    endtask

    task automatic doRead(input int k, input bit sel, input bit [31:0] addr, input int len,
                          input int stallWord, input int stallLen, input bit randStall);
        int n;
        int s;
        bit [31:0] a;
        bit [31:0] exp;
        issue(k, 2'b01, sel, addr, $urandom, 4'($urandom), len);
        for (int w = 0; w <= len; w++) begin
            a = (addr & 32'hFFFF_FFFC) + 32'(4 * w);
            exp = shadowRead(k, sel, a);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (rsp_valid[k] !== 1'b1 && n < 20);
            check("rd_latency", n, latOf(k) + 1);
            check("rd_data", rsp_data[k], exp);
            check("rd_last", rsp_last[k], (w == len));
            s = randStall ? $urandom_range(0, 2) : ((w == stallWord) ? stallLen : 0);
            for (int c = 0; c < s; c++) begin
                @(negedge clk);
                check("rd_stall_hold", {rsp_valid[k], rsp_last[k], rsp_data[k]}, {1'b1, (w == len), exp});
            end
            rsp_ready[k] = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready[k] = 1'b0;
        end
        @(negedge clk);
        check("rd_done", {busy[k], rsp_valid[k]}, 2'b00);
        compareLog("rd_no_writes");
    endtask

    // ------------------------------------------------------------------
    // Directed sequence followed by randomized traffic
    // ------------------------------------------------------------------
    int        rk, rop, rlen;
    bit        rsel;
    bit [31:0] raddr;

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_op[k] = '0; cmd_sel[k] = 1'b0; cmd_addr[k] = '0;
            cmd_wdata[k] = '0; cmd_be[k] = '0; cmd_len[k] = '0; rsp_ready[k] = 1'b0;
            curSel[k] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_ctrl", {cmd_ready[k], busy[k], rsp_valid[k], rsp_last[k], cpu_hold[k]}, 5'b00001);
            check("reset_rsp_data", rsp_data[k], 32'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_before_edge", cmd_ready[0], 1'b0);
        @(negedge clk);
        check("ready_after_edge_a", cmd_ready[0], 1'b1);
        check("ready_after_edge_b", cmd_ready[1], 1'b1);
        monEn = 1'b1;

        // T1: single write then single-word read back
        doWrite(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        doRead(0, 1'b1, 32'h10, 0, 0, 0, 1'b0);
        doWrite(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
        doRead(1, 1'b1, 32'h10, 0, 0, 0, 1'b0);

        // Unaligned address is forced onto a word boundary
        doWrite(0, 1'b0, 32'h22, 32'h01234567, 4'hF);
        doRead(0, 1'b0, 32'h20, 0, 0, 0, 1'b0);

        // T2: three-word burst with a 3-cycle stall on the second word
        for (int i = 0; i < 3; i++) begin
            doWrite(0, 1'b0, 32'h100 + 32'(4 * i), $urandom, 4'hF);
            doWrite(1, 1'b0, 32'h100 + 32'(4 * i), $urandom, 4'hF);
        end
        doRead(0, 1'b0, 32'h100, 2, 1, 3, 1'b0);
        doRead(1, 1'b0, 32'h100, 2, 1, 3, 1'b0);

        // T3: fill across the top of the address space, low halves only
        doFill(0, 1'b0, 32'hFFFFFFF8, 32'hA5A5C3C3, 4'h3, 3);
        doRead(0, 1'b0, 32'hFFFFFFF8, 3, 0, 0, 1'b1);
        // Fill with no byte enables still walks len+1 cycles
        doFill(0, 1'b1, 32'h40, 32'h55AA55AA, 4'h0, 2);
        // Longest burst the length field allows
        doFill(0, 1'b1, 32'h400, 32'h0BADF00D, 4'hF, (1 << LW) - 1);
        doWrite(0, 1'b1, 32'h43C, 32'h600DCAFE, 4'hC);
        doRead(0, 1'b1, 32'h400, (1 << LW) - 1, 0, 0, 1'b1);

        // T4: run/hold
        doRun(0, 1'b0);
        doRun(0, 1'b1);
        doRun(1, 1'b0);

        // T6: RD_LAT=3 two-word read
        doWrite(1, 1'b1, 32'h80, $urandom, 4'hF);
        doWrite(1, 1'b1, 32'h84, $urandom, 4'hF);
        doRead(1, 1'b1, 32'h80, 1, 0, 0, 1'b0);

        // T5: reset during the third RD_WAIT of a six-word read
        issue(1, 2'b01, 1'b0, 32'h200, 32'd0, 4'd0, 5);
        rk = 0;
        do begin
            @(negedge clk);
            rk++;
        end while (rsp_valid[1] !== 1'b1 && rk < 20);
        check("t5_first_word", rsp_valid[1], 1'b1);
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
        @(posedge clk);
        #2;
        check("t5_pre_reset_a2", inst_a2[1], 32'h204);
        monEn = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_reset_ctrl", {rsp_valid[1], busy[1], cmd_ready[1], cpu_hold[1], cpu_hold[0]}, 5'b00011);
        check("t5_reset_ports", |{inst_a2[1], inst_wd2[1], inst_we2[1], data_a2[1], data_wd2[1], data_we2[1]}, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_ready_low", cmd_ready[1], 1'b0);
        @(negedge clk);
        check("t5_ready_high", cmd_ready[1], 1'b1);
        monEn = 1'b1;
        compareLog("t5_no_writes");
        doWrite(1, 1'b1, 32'h30, 32'h13579BDF, 4'hF);
        doRead(1, 1'b1, 32'h30, 0, 0, 0, 1'b0);

        // Randomized traffic on both instances
        for (int i = 0; i < 40; i++) begin
            rk   = $urandom_range(0, 1);
            rop  = $urandom_range(0, 3);
            rsel = 1'($urandom_range(0, 1));
            rlen = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0)
                raddr = 32'hFFFFFFF0 + 32'($urandom_range(0, 3) << 2);
            else
                raddr = (32'h100 + 32'($urandom_range(0, 31) << 2)) | 32'($urandom_range(0, 3));
            case (rop)
                0: doWrite(rk, rsel, raddr, $urandom, 4'($urandom_range(0, 15)));
                1: doRead(rk, rsel, raddr, rlen, 0, 0, 1'b1);
                2: doFill(rk, rsel, raddr, $urandom, 4'($urandom_range(0, 15)), rlen);
                default: doRun(rk, 1'($urandom_range(0, 1)));
            endcase
        end

        // Final RAM contents against the shadow memory
        foreach (shadow[key])
            check("ram_contents", ram.exists(key) ? ram[key] : 32'd0, shadow[key]);

        monEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
